// File: rtl/charlie_scan.sv
// charlie_scan: Wishbone-addressable charlieplexed LED scanner.
//
// Build option: define CHARLIE_SCAN_PWM_EN to light a column only while
// pixel > step, which gives 8-bit PWM brightness. With the macro undefined,
// any non-zero pixel is fully on for steps 1..255.
//
// Scan order: each row (one pin driven high) is held for 256 PWM steps.
// Step 0 of every row is a fully blanked dead-time slot. Lit columns of the
// row are driven low. Every other pin is tri-stated.
//
// Pixel index = row*(PINS-1) + k. Here k is the column's position among the
// pins other than the row pin, counted in ascending pin order.
module charlie_scan #(
    parameter int  PINS           = 7,
    parameter int  TICKS_PER_STEP = 48,
    localparam int LEDS           = PINS * (PINS - 1),
    localparam int AW             = $clog2(LEDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [7:0]      wb_dat_i,
    output logic [7:0]      wb_dat_o,
    output logic            wb_ack_o,
    output logic [PINS-1:0] charlie_oe,
    output logic [PINS-1:0] charlie_o
);

    localparam int PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int RW = $clog2(PINS);

    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_STEP - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PINS - 1);

    // Column lit decision for one pixel at the current PWM step
    function automatic logic pixel_on(input logic [7:0] pix, input logic [7:0] step);
`ifdef CHARLIE_SCAN_PWM_EN
        return (pix > step);
`else
        return (pix != 8'h00) && (step != 8'h00);
`endif
    endfunction

    // Pixel store and bus registers
    logic [7:0]      r_pix [LEDS];
    logic            r_ack;
    logic [7:0]      r_dat;

    // Scan counters
    logic [PW-1:0]   r_pre;
    logic [7:0]      r_step;
    logic [RW-1:0]   r_row;

    // Registered pin drivers
    logic [PINS-1:0] r_oe;
    logic [PINS-1:0] r_o;

    logic            w_req;
    logic            w_adr_ok;
    logic [7:0]      w_rd_dat;
    logic            w_pre_wrap;
    logic [PINS-1:0] w_lit;
    logic [PINS-1:0] w_oe;
    logic [PINS-1:0] w_o;

    // Bus request decode and read-data mux (out-of-range reads as zero)
    always_comb begin
        w_req    = wb_cyc_i & wb_stb_i;
        w_adr_ok = (int'(wb_adr_i) < LEDS);
        w_rd_dat = 8'h00;
        if (w_adr_ok) begin
            w_rd_dat = r_pix[wb_adr_i];
        end
    end

    // Bus slave: one-cycle ack after a new request. The write commits on the
    // same edge that raises ack, so the scan reading this pixel at that edge
    // still sees the old value. Reset clears every pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack <= 1'b0;
            r_dat <= 8'h00;
            for (int i = 0; i < LEDS; i++) begin
                r_pix[i] <= 8'h00;
            end
        end else begin
            r_ack <= w_req & ~r_ack;
            if (w_req && !r_ack) begin
                r_dat <= w_rd_dat;
                if (wb_we_i && w_adr_ok) begin
                    r_pix[wb_adr_i] <= wb_dat_i;
                end
            end
        end
    end

    assign w_pre_wrap = (r_pre == PRE_LAST);

    // Scan timebase: prescaler -> 8-bit PWM step -> row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre  <= '0;
            r_step <= 8'h00;
            r_row  <= '0;
        end else if (w_pre_wrap) begin
            r_pre  <= '0;
            r_step <= r_step + 8'd1;
            if (r_step == 8'hFF) begin
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
            end
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // Per-column lit mask for the current row and step
    always_comb begin
        int idx;
        idx   = 0;
        w_lit = '0;
        for (int p = 0; p < PINS; p++) begin
            if (p != int'(r_row)) begin
                idx = int'(r_row) * (PINS - 1) + ((p < int'(r_row)) ? p : p - 1);
                w_lit[p] = pixel_on(r_pix[idx[AW-1:0]], r_step);
            end
        end
    end

    // Pin pattern: step 0 blanked; otherwise the row pin is high, lit columns
    // are low, and the rest float. Only the row pin can ever be driven high.
    always_comb begin
        w_oe = '0;
        w_o  = '0;
        if (r_step != 8'h00) begin
            for (int p = 0; p < PINS; p++) begin
                if (p == int'(r_row)) begin
                    w_oe[p] = 1'b1;
                    w_o[p]  = 1'b1;
                end else if (w_lit[p]) begin
                    w_oe[p] = 1'b1;
                end
            end
        end
    end

    // Output register: one cycle from counter state to pins; reset floats all pins at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oe <= '0;
            r_o  <= '0;
        end else begin
            r_oe <= w_oe;
            r_o  <= w_o;
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat;
    assign charlie_oe = r_oe;
    assign charlie_o  = r_o;

endmodule

// File: tb/tb_charlie_scan.sv
// Testbench for charlie_scan at PINS=4, TICKS_PER_STEP=1 (one step per clk).
// The expected pin patterns follow CHARLIE_SCAN_PWM_EN when the macro is defined.
module tb_charlie_scan;

    localparam int PINS = 4;
    localparam int TPS  = 1;
    localparam int AW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wb_cyc_i = 1'b0;
    logic            wb_stb_i = 1'b0;
    logic            wb_we_i  = 1'b0;
    logic [AW-1:0]   wb_adr_i = '0;
    logic [7:0]      wb_dat_i = 8'h00;
    logic [7:0]      wb_dat_o;
    logic            wb_ack_o;
    logic [PINS-1:0] charlie_oe;
    logic [PINS-1:0] charlie_o;

    charlie_scan #(.PINS(PINS), .TICKS_PER_STEP(TPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .charlie_oe (charlie_oe),
        .charlie_o  (charlie_o)
    );

    always #5 clk = ~clk;

    // Edges since reset release; pins seen after edge n show scan position n-1
    int tcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) tcnt <= 0;
        else     tcnt <= tcnt + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       we;
        logic [3:0] adr;
        logic [7:0] dat;
        logic [7:0] exp;
    } bus_vec_t;

    typedef struct {
        int         row;
        int         step;
        logic [3:0] oe;
        logic [3:0] o;
    } scan_vec_t;

    localparam int NB = 15;
    localparam int NS = 19;
    bus_vec_t  bus_tab  [NB];
    scan_vec_t scan_tab [NS];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [3:0] adr, input logic [7:0] dat,
                            output logic [7:0] rd);
        int lat;
        lat = -1;
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack_o) begin
                lat = i;
                break;
            end
        end
        rd = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        check($sformatf("ack_latency_adr%0d", adr), lat, 0);
        @(negedge clk);
        check($sformatf("ack_single_adr%0d", adr), int'(wb_ack_o), 0);
    endtask

    // Advance to the negedge where the pins show (row r, step s); bounded by one frame
    task automatic wait_pos(input int r, input int s);
        int found;
        found = 0;
        for (int i = 0; i < 1100 && found == 0; i++) begin
            @(negedge clk);
            if (tcnt >= 1 && ((tcnt - 1) % 256) == s && (((tcnt - 1) / 256) % 4) == r)
                found = 1;
        end
        if (found == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_pos r%0d s%0d: position not reached within bound", r, s);
        end
    endtask

    function automatic scan_vec_t sv(input int r, input int s, input logic [3:0] oe, input logic [3:0] o);
        scan_vec_t v;
        v.row = r; v.step = s; v.oe = oe; v.o = o;
        return v;
    endfunction

    function automatic bus_vec_t bv(input logic we, input logic [3:0] adr, input logic [7:0] dat, input logic [7:0] exp);
        bus_vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.exp = exp;
        return v;
    endfunction

    initial begin
        logic [7:0] rd;
        int         run;
        logic [3:0] row_o;
        logic [3:0] nxt_o;

        // Bus vectors: leave pixel 0=FF, 3=10, 5=80, 11=01, all others 0
        bus_tab[0]  = bv(1'b1, 4'd5,  8'h80, 8'h00);
        bus_tab[1]  = bv(1'b0, 4'd5,  8'h00, 8'h80);
        bus_tab[2]  = bv(1'b1, 4'd12, 8'h55, 8'h00);
        bus_tab[3]  = bv(1'b0, 4'd12, 8'h00, 8'h00);
        bus_tab[4]  = bv(1'b0, 4'd0,  8'h00, 8'h00);
        bus_tab[5]  = bv(1'b1, 4'd0,  8'hFF, 8'h00);
        bus_tab[6]  = bv(1'b0, 4'd0,  8'h00, 8'hFF);
        bus_tab[7]  = bv(1'b1, 4'd11, 8'h01, 8'h00);
        bus_tab[8]  = bv(1'b0, 4'd11, 8'h00, 8'h01);
        bus_tab[9]  = bv(1'b1, 4'd3,  8'h10, 8'h00);
        bus_tab[10] = bv(1'b0, 4'd3,  8'h00, 8'h10);
        bus_tab[11] = bv(1'b0, 4'd5,  8'h00, 8'h80);
        bus_tab[12] = bv(1'b1, 4'd15, 8'hAA, 8'h00);
        bus_tab[13] = bv(1'b0, 4'd15, 8'h00, 8'h00);
        bus_tab[14] = bv(1'b0, 4'd4,  8'h00, 8'h00);

        // Scan vectors. Row r drives pin r high. The columns are:
        // row0 -> pins 1,2,3 = pix 0,1,2
        // row1 -> pins 0,2,3 = pix 3,4,5
        // row2 -> pins 0,1,3 = pix 6,7,8
        // row3 -> pins 0,1,2 = pix 9,10,11
        scan_tab[0]  = sv(0, 0,   4'b0000, 4'b0000);
        scan_tab[1]  = sv(0, 1,   4'b0011, 4'b0001);
        scan_tab[2]  = sv(0, 128, 4'b0011, 4'b0001);
`ifdef CHARLIE_SCAN_PWM_EN
        scan_tab[3]  = sv(0, 255, 4'b0001, 4'b0001);
`else
        scan_tab[3]  = sv(0, 255, 4'b0011, 4'b0001);
`endif
        scan_tab[4]  = sv(1, 0,   4'b0000, 4'b0000);
        scan_tab[5]  = sv(1, 1,   4'b1011, 4'b0010);
        scan_tab[6]  = sv(1, 15,  4'b1011, 4'b0010);
`ifdef CHARLIE_SCAN_PWM_EN
        scan_tab[7]  = sv(1, 16,  4'b1010, 4'b0010);
        scan_tab[8]  = sv(1, 127, 4'b1010, 4'b0010);
        scan_tab[9]  = sv(1, 128, 4'b0010, 4'b0010);
        scan_tab[10] = sv(1, 255, 4'b0010, 4'b0010);
`else
        scan_tab[7]  = sv(1, 16,  4'b1011, 4'b0010);
        scan_tab[8]  = sv(1, 127, 4'b1011, 4'b0010);
        scan_tab[9]  = sv(1, 128, 4'b1011, 4'b0010);
        scan_tab[10] = sv(1, 255, 4'b1011, 4'b0010);
`endif
        scan_tab[11] = sv(2, 0,   4'b0000, 4'b0000);
        scan_tab[12] = sv(2, 5,   4'b0100, 4'b0100);
        scan_tab[13] = sv(2, 255, 4'b0100, 4'b0100);
        scan_tab[14] = sv(3, 0,   4'b0000, 4'b0000);
`ifdef CHARLIE_SCAN_PWM_EN
        scan_tab[15] = sv(3, 1,   4'b1000, 4'b1000);
        scan_tab[16] = sv(3, 200, 4'b1000, 4'b1000);
        scan_tab[17] = sv(3, 255, 4'b1000, 4'b1000);
`else
        scan_tab[15] = sv(3, 1,   4'b1100, 4'b1000);
        scan_tab[16] = sv(3, 200, 4'b1100, 4'b1000);
        scan_tab[17] = sv(3, 255, 4'b1100, 4'b1000);
`endif
        scan_tab[18] = sv(0, 0,   4'b0000, 4'b0000);

        // Reset state, with a request held to show no ack while in reset
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_oe",  int'(charlie_oe), 0);
        check("rst_o",   int'(charlie_o), 0);
        check("rst_ack", int'(wb_ack_o), 0);
        check("rst_dat", int'(wb_dat_o), 0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        rst = 1'b0;

        // Bus transactions
        for (int i = 0; i < NB; i++) begin
            bus_xfer(bus_tab[i].we, bus_tab[i].adr, bus_tab[i].dat, rd);
            if (!bus_tab[i].we)
                check($sformatf("rd_adr%0d", bus_tab[i].adr), int'(rd), int'(bus_tab[i].exp));
        end

        // Request held high: ack pulses with a gap, never back to back
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 4'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("held_ack%0d", i), int'(wb_ack_o), (i % 2 == 0) ? 1 : 0);
            if (i == 0) check("held_dat", int'(wb_dat_o), 8'h80);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;

        // Scan patterns across a full frame
        for (int i = 0; i < NS; i++) begin
            wait_pos(scan_tab[i].row, scan_tab[i].step);
            check($sformatf("oe_r%0d_s%0d", scan_tab[i].row, scan_tab[i].step),
                  int'(charlie_oe), int'(scan_tab[i].oe));
            check($sformatf("o_r%0d_s%0d", scan_tab[i].row, scan_tab[i].step),
                  int'(charlie_o), int'(scan_tab[i].o));
        end

        // Row sequence 0,1,2,3,0: each row high for 255 steps, then one blank step
        wait_pos(0, 1);
        for (int r = 0; r < 4; r++) begin
            row_o = 4'b0001 << r;
            nxt_o = 4'b0001 << ((r + 1) % 4);
            run = 1;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (charlie_o == row_o) run++;
                else break;
            end
            check($sformatf("row%0d_run", r), run, 255);
            check($sformatf("row%0d_blank_oe", r), int'(charlie_oe), 0);
            @(negedge clk);
            check($sformatf("row%0d_next_o", r), int'(charlie_o), int'(nxt_o));
        end

        // Reset mid-row with a write pending
        wait_pos(2, 100);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 4'd0;
        wb_dat_i = 8'h33;
        rst = 1'b1;
        #1;
        check("midrst_oe_now", int'(charlie_oe), 0);
        check("midrst_o_now",  int'(charlie_o), 0);
        check("midrst_ack_now", int'(wb_ack_o), 0);
        @(negedge clk);
        check("midrst_oe_next", int'(charlie_oe), 0);
        check("midrst_ack_next", int'(wb_ack_o), 0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_step0_oe", int'(charlie_oe), 0);
        @(negedge clk);
        check("post_rst_r0s1_oe", int'(charlie_oe), 4'b0001);
        check("post_rst_r0s1_o",  int'(charlie_o),  4'b0001);
        for (int a = 0; a < 12; a += 3) begin
            bus_xfer(1'b0, 4'(a), 8'h00, rd);
            check($sformatf("post_rst_rd_adr%0d", a), int'(rd), 0);
        end
        bus_xfer(1'b0, 4'd5, 8'h00, rd);
        check("post_rst_rd_adr5", int'(rd), 0);
        bus_xfer(1'b0, 4'd11, 8'h00, rd);
        check("post_rst_rd_adr11", int'(rd), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
